// File: rtl/inst_loader.sv
`default_nettype none
// ============================================================================
// Module      : inst_loader
// Description : Packs a byte stream into 32-bit little-endian words and writes
//               them to consecutive instruction-memory addresses. The CPU is
//               held in reset until a full image is in place.
//               Optional macro CHECKSUM_EN adds a trailing XOR checksum byte.
// Revision    : 1.0 - initial release
// ============================================================================
module inst_loader #(
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              cpu_hold,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int               CNT_W   = ADDR_W + 1;
  localparam logic [31:0]      DEPTH   = 32'd1 << ADDR_W;
  localparam logic [CNT_W-1:0] DEPTH_N = DEPTH[CNT_W-1:0];

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_HDR   = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRITE = 3'd3;
  localparam logic [2:0] S_CHK   = 3'd4;
  localparam logic [2:0] S_DONE  = 3'd5;

  logic [2:0]        state_q,  state_d;
  logic [1:0]        bcnt_q,   bcnt_d;
  logic [CNT_W-1:0]  wcnt_q,   wcnt_d;
  logic [CNT_W-1:0]  nwords_q, nwords_d;
  logic [ADDR_W-1:0] addr_q,   addr_d;
  logic [31:0]       wdata_q,  wdata_d;
`ifdef CHECKSUM_EN
  logic [7:0]        csum_q,   csum_d;
  logic              err_q,    err_d;
`endif

  logic              accept;
  logic              start_ok;
  logic [CNT_W-1:0]  hdr_n;
  logic [CNT_W-1:0]  wcnt_inc;
  logic              last_word;

  assign accept    = byte_valid && byte_ready;
  assign start_ok  = start && ((state_q == S_IDLE) || (state_q == S_DONE));
  assign wcnt_inc  = wcnt_q + 1'b1;
  assign last_word = (wcnt_inc == nwords_q);

  // Header 0 means a full memory; anything beyond the memory size is clamped.
  assign hdr_n = ((byte_in == 8'd0) || ({24'd0, byte_in} > DEPTH)) ? DEPTH_N
                                                                   : CNT_W'(byte_in);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bcnt_q   <= 2'd0;
      wcnt_q   <= '0;
      nwords_q <= '0;
      addr_q   <= '0;
      wdata_q  <= 32'd0;
`ifdef CHECKSUM_EN
      csum_q   <= 8'd0;
      err_q    <= 1'b0;
`endif
    end else begin
      bcnt_q   <= bcnt_d;
      wcnt_q   <= wcnt_d;
      nwords_q <= nwords_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
`ifdef CHECKSUM_EN
      csum_q   <= csum_d;
      err_q    <= err_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_DONE: if (start) state_d = S_HDR;
      S_HDR:          if (accept) state_d = S_DATA;
      S_DATA:         if (accept && (bcnt_q == 2'd3)) state_d = S_WRITE;
      S_WRITE: begin
        if (!last_word) begin
          state_d = S_DATA;
        end else begin
`ifdef CHECKSUM_EN
          state_d = S_CHK;
`else
          state_d = S_DONE;
`endif
        end
      end
`ifdef CHECKSUM_EN
      S_CHK:          if (accept) state_d = (byte_in == csum_q) ? S_DONE : S_IDLE;
`endif
      default:        state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bcnt_d   = bcnt_q;
    wcnt_d   = wcnt_q;
    nwords_d = nwords_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
`ifdef CHECKSUM_EN
    csum_d   = csum_q;
    err_d    = err_q;
`endif
    if (start_ok) begin
      bcnt_d = 2'd0;
      wcnt_d = '0;
      addr_d = '0;
`ifdef CHECKSUM_EN
      csum_d = 8'd0;
      err_d  = 1'b0;
`endif
    end
    if ((state_q == S_HDR) && accept) begin
      nwords_d = hdr_n;
    end
    if ((state_q == S_DATA) && accept) begin
      wdata_d[{bcnt_q, 3'b000} +: 8] = byte_in;
      bcnt_d                         = bcnt_q + 2'd1;
`ifdef CHECKSUM_EN
      csum_d                         = csum_q ^ byte_in;
`endif
    end
    // Address advances after every write, so a full image wraps back to 0.
    if (state_q == S_WRITE) begin
      wcnt_d = wcnt_inc;
      addr_d = addr_q + 1'b1;
    end
`ifdef CHECKSUM_EN
    if ((state_q == S_CHK) && accept && (byte_in != csum_q)) begin
      err_d = 1'b1;
    end
`endif
  end

  always_comb begin
    byte_ready = (state_q == S_HDR) || (state_q == S_DATA) || (state_q == S_CHK);
    mem_we     = (state_q == S_WRITE);
    mem_addr   = addr_q;
    mem_wdata  = wdata_q;
    cpu_hold   = (state_q != S_DONE);
    busy       = (state_q == S_HDR) || (state_q == S_DATA) ||
                 (state_q == S_WRITE) || (state_q == S_CHK);
    done       = (state_q == S_DONE);
`ifdef CHECKSUM_EN
    err        = err_q;
`else
    err        = 1'b0;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_inst_loader.sv
`default_nettype none
// ============================================================================
// Module      : tb_inst_loader
// Description : Randomised self-checking bench for inst_loader (ADDR_W=6);
//               honours CHECKSUM_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_inst_loader;

  localparam int ADDR_W = 6;
  localparam int DEPTH  = 64;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              byte_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;
  logic              cpu_hold;
  logic              busy;
  logic              done;
  logic              err;

  inst_loader #(.ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .byte_ready (byte_ready),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .cpu_hold   (cpu_hold),
    .busy       (busy),
    .done       (done),
    .err        (err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;
  bit tog   = 1'b0;

  logic [ADDR_W-1:0] obs_a[$];
  logic [31:0]       obs_d[$];
  logic [7:0]        payload [0:255];

  always @(negedge clk) begin
    if (rst && mem_we) begin
      obs_a.push_back(mem_addr);
      obs_d.push_back(mem_wdata);
    end
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_reset(input string tag);
    check_eq({tag, "_rdy"},  byte_ready, 0);
    check_eq({tag, "_we"},   mem_we,     0);
    check_eq({tag, "_addr"}, mem_addr,   0);
    check_eq({tag, "_wd"},   mem_wdata,  0);
    check_eq({tag, "_hold"}, cpu_hold,   1);
    check_eq({tag, "_busy"}, busy,       0);
    check_eq({tag, "_done"}, done,       0);
    check_eq({tag, "_err"},  err,        0);
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // mode 0: valid always, 1: valid toggles every cycle, 2: random valid
  task automatic send_byte(input logic [7:0] b, input int mode);
    bit sent  = 1'b0;
    int guard = 0;
    while (!sent && guard < 64) begin
      byte_in = b;
      case (mode)
        0:       byte_valid = 1'b1;
        1:       begin tog = ~tog; byte_valid = tog; end
        default: byte_valid = 1'($urandom_range(0, 1));
      endcase
      sent = byte_valid && byte_ready;
      @(posedge clk); #1;
      guard++;
    end
    byte_valid = 1'b0;
    if (!sent) check_eq("send_timeout", 0, 1);
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) payload[i] = 8'($urandom);
  endtask

  // Expected image: word i of N lands at address i, bytes packed little-endian.
  task automatic run_load(input string tag, input logic [7:0] hdr, input int mode,
                          input bit bad_chk);
    int         n_eff;
    int         base;
    int         nobs;
    logic [7:0] x;
    logic [31:0] expw;
    bit         exp_err;
    n_eff = (hdr == 8'd0 || int'(hdr) > DEPTH) ? DEPTH : int'(hdr);
    base  = obs_a.size();
    x     = 8'd0;
    pulse_start();
    check_eq({tag, "_s_busy"}, busy,     1);
    check_eq({tag, "_s_hold"}, cpu_hold, 1);
    check_eq({tag, "_s_done"}, done,     0);
    check_eq({tag, "_s_err"},  err,      0);
    check_eq({tag, "_s_addr"}, mem_addr, 0);
    send_byte(hdr, mode);
    for (int i = 0; i < n_eff * 4; i++) begin
      send_byte(payload[i], mode);
      x ^= payload[i];
    end
`ifdef CHECKSUM_EN
    send_byte(bad_chk ? (x ^ 8'h01) : x, mode);
    exp_err = bad_chk;
`else
    exp_err = 1'b0;
`endif
    for (int k = 0; k < 20 && !(done || err); k++) begin
      @(posedge clk); #1;
    end
    nobs = obs_a.size() - base;
    check_eq({tag, "_nwr"}, nobs, n_eff);
    for (int i = 0; i < n_eff && i < nobs; i++) begin
      expw = {payload[4*i+3], payload[4*i+2], payload[4*i+1], payload[4*i]};
      check_eq({tag, "_waddr"}, obs_a[base+i], i);
      check_eq({tag, "_wdata"}, obs_d[base+i], expw);
    end
    check_eq({tag, "_f_done"}, done,       !exp_err);
    check_eq({tag, "_f_hold"}, cpu_hold,   exp_err);
    check_eq({tag, "_f_err"},  err,        exp_err);
    check_eq({tag, "_f_busy"}, busy,       0);
    check_eq({tag, "_f_rdy"},  byte_ready, 0);
    check_eq({tag, "_f_addr"}, mem_addr,   n_eff % DEPTH);
  endtask

  initial begin
    int base;
    rst        = 1'b0;
    start      = 1'b0;
    byte_in    = 8'd0;
    byte_valid = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    @(posedge clk); #1;
    check_reset("rst0");

    // Bytes offered in IDLE are never taken.
    byte_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    byte_valid = 1'b0;
    check_eq("idle_rdy",  byte_ready, 0);
    check_eq("idle_busy", busy,       0);

    // Two-word directed image, then the same with a stuttering stream.
    payload[0] = 8'h78; payload[1] = 8'h56; payload[2] = 8'h34; payload[3] = 8'h12;
    payload[4] = 8'hEF; payload[5] = 8'hBE; payload[6] = 8'hAD; payload[7] = 8'hDE;
    for (int pass = 0; pass < 2; pass++) begin
      base = obs_a.size();
      run_load(pass == 0 ? "dir" : "tog", 8'h02, pass, 1'b0);
      if (obs_a.size() >= base + 2) begin
        check_eq("dir_w0", obs_d[base],   32'h12345678);
        check_eq("dir_w1", obs_d[base+1], 32'hDEADBEEF);
      end
    end

    fill_random();
    run_load("full", 8'h00, 0, 1'b0);
    fill_random();
    run_load("clamp", 8'd100, 2, 1'b0);
    for (int r = 0; r < 4; r++) begin
      fill_random();
      run_load("rnd", 8'($urandom_range(1, 20)), int'($urandom_range(0, 2)), 1'b0);
    end
`ifdef CHECKSUM_EN
    fill_random();
    run_load("badck", 8'd3, 2, 1'b1);
    fill_random();
    run_load("goodck", 8'd3, 1, 1'b0);
`endif

    // Start ignored mid-load, then asynchronous reset with a partial word.
    base = obs_a.size();
    pulse_start();
    send_byte(8'd3, 0);
    send_byte(8'hA1, 0);
    send_byte(8'hB2, 0);
    pulse_start();
    check_eq("ign_busy", busy,       1);
    check_eq("ign_rdy",  byte_ready, 1);
    send_byte(8'hC3, 0);
    send_byte(8'hD4, 0);
    @(posedge clk); #1;
    check_eq("ign_nwr", obs_a.size() - base, 1);
    if (obs_a.size() > base) begin
      check_eq("ign_addr", obs_a[base], 0);
      check_eq("ign_data", obs_d[base], 32'hD4C3B2A1);
    end
    send_byte(8'h11, 0);
    send_byte(8'h22, 0);
    #2 rst = 1'b0;
    #1 check_reset("arst");
    @(posedge clk); #1;
    check_reset("arst_hold");
    rst = 1'b1;
    @(posedge clk); #1;
    check_eq("arst_nwr", obs_a.size() - base, 1);

    fill_random();
    run_load("after", 8'd2, 2, 1'b0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1);
  end

endmodule
`default_nettype wire
